reg_file_param: RTL
===================

Name: reg_file_param

Overview:
Parametrised general-purpose register file, the successor to the single Load-enabled 32-bit register. Generalised in width, register count and read-port count. Adds asynchronous active-low reset, optional write-to-read bypass, and a dedicated program-counter register (highest index) with its own load and auto-increment. Sits in the decode/writeback stages of the ARM datapath and feeds the operand muxes.

Parameters:
WIDTH, 32, data width of every register in bits
NREGS, 16, number of registers; index NREGS-1 is the PC
AW, 4, address width; must satisfy 2**AW >= NREGS
NRD, 3, number of combinational read ports
BYPASS, 1, 1 = a same-cycle write to an address is visible on the read ports; 0 = read returns the stored value
PC_STEP, 4, PC auto-increment amount
PC_RD_OFS, 8, offset added to the PC when the PC is read through a general read port

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous active-low reset
We  input  1  general write enable
Wa  input  AW  write address
Wd  input  WIDTH  write data
Ra  input  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW]
Rd  output  NRD*WIDTH  packed read data; port k uses bits [k*WIDTH +: WIDTH]
Pc_ld  input  1  load PC from Pc_in (branch)
Pc_in  input  WIDTH  branch target
Pc_inc  input  1  advance PC by PC_STEP (fetch not stalled)
Pc_out  output  WIDTH  current PC register value, registered

Behaviour:
- One clock, Clk. Reset is asynchronous and active-low on Reset_n.
- Reset_n low: all NREGS registers, including the PC, clear to 0 immediately, independent of Clk. Pc_out = 0. Rd reflects the cleared registers, plus any bypass.
- Reset deasserts: the first state update occurs on the first Clk rising edge with Reset_n high. An operation in flight during reset is discarded; there is no partial update.
- General write on a rising edge when We=1 and Wa < NREGS-1: reg[Wa] <= Wd. If Wa >= NREGS, the write is ignored.
- PC update on a rising edge, priority highest first:
  - Pc_ld: PC <= Pc_in
  - We with Wa == NREGS-1: PC <= Wd
  - Pc_inc: PC <= PC + PC_STEP, modulo 2**WIDTH (wraps silently)
  - none of the above: PC holds
- A lower-priority PC source in the same cycle is dropped entirely, including Pc_inc.
- Reads are combinational, zero latency. For each port k:
  - Ra_k < NREGS-1: Rd_k = reg[Ra_k]
  - Ra_k == NREGS-1: Rd_k = PC + PC_RD_OFS, modulo 2**WIDTH
  - Ra_k >= NREGS: Rd_k = 0
- Bypass, when BYPASS=1, We=1 and Wa == Ra_k:
  - If Wa < NREGS-1, Rd_k = Wd.
  - If Wa == NREGS-1, Rd_k = Wd + PC_RD_OFS; this is a write-winning view and ignores Pc_ld.
- Bypass, when BYPASS=0: the new value appears on Rd the cycle after the write edge.
- All read ports are independent. Any number of ports may address the same register.
- Write latency: one edge. Pc_out changes only on an edge or on reset.

Test Plan:
- Reset: hold Reset_n=0 mid-cycle after writing R3=0xDEADBEEF -> R3 reads 0 and Pc_out=0 before the next edge.
- Write/read: We=1, Wa=2, Wd=0x12345678 for one edge; Ra={2,2,5} -> all ports read the stored values next cycle, R5=0. With BYPASS=1, port 0 shows 0x12345678 in the write cycle itself.
- PC increment and read offset: after reset, 3 edges with Pc_inc=1 -> Pc_out=12. Reading index 15 -> Rd=20. Starting from PC=0xFFFFFFFC, one increment -> Pc_out=0.
- PC priority: in one edge, Pc_ld=1 with Pc_in=0x100, We=1 to Wa=15 with Wd=0x200, and Pc_inc=1 -> Pc_out=0x100. Next edge with We/Wa=15/0x200 and Pc_inc=1 -> Pc_out=0x200.
- Out-of-range: NREGS=12, AW=4; write Wa=13 -> no register changes; Ra=13 -> Rd=0.
- BYPASS=0 variant: write R7=0xA5A5A5A5 -> the same-cycle read returns the old value 0, and the next cycle returns 0xA5A5A5A5.

Source files
------------

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
// reg_file_param : parametrised register file, top index is the PC
// Rev 1.0
// ============================================================================
module reg_file_param #(
  parameter int WIDTH     = 32,
  parameter int NREGS     = 16,
  parameter int AW        = 4,
  parameter int NRD       = 3,
  parameter int BYPASS    = 1,
  parameter int PC_STEP   = 4,
  parameter int PC_RD_OFS = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 We,
  input  logic [AW-1:0]        Wa,
  input  logic [WIDTH-1:0]     Wd,
  input  logic [NRD*AW-1:0]    Ra,
  output logic [NRD*WIDTH-1:0] Rd,
  input  logic                 Pc_ld,
  input  logic [WIDTH-1:0]     Pc_in,
  input  logic                 Pc_inc,
  output logic [WIDTH-1:0]     Pc_out
);

  localparam logic [AW-1:0]    c_pc_idx  = AW'(NREGS - 1);
  localparam logic [WIDTH-1:0] c_pc_step = WIDTH'(PC_STEP);
  localparam logic [WIDTH-1:0] c_rd_ofs  = WIDTH'(PC_RD_OFS);
  localparam int               c_ngen    = NREGS - 1;

  logic [WIDTH-1:0] regs_q [c_ngen];
  logic [WIDTH-1:0] regs_d [c_ngen];
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             w_wr_pc;

  assign w_wr_pc = We && (Wa == c_pc_idx);

  // Out-of-range write addresses match no general register and not the PC.
  always_comb begin
    for (int i = 0; i < c_ngen; i++) begin
      regs_d[i] = (We && (Wa == AW'(i))) ? Wd : regs_q[i];
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (Pc_ld) begin
      pc_d = Pc_in;
    end else if (w_wr_pc) begin
      pc_d = Wd;
    end else if (Pc_inc) begin
      pc_d = pc_q + c_pc_step;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < c_ngen; i++) begin
        regs_q[i] <= '0;
      end
      pc_q <= '0;
    end else begin
      for (int i = 0; i < c_ngen; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pc_q <= pc_d;
    end
  end

  assign Pc_out = pc_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    w_ra;
    logic [WIDTH-1:0] w_stored;
    logic [WIDTH-1:0] w_rd;
    logic             w_hit;

    assign w_ra  = Ra[k*AW +: AW];
    assign w_hit = (BYPASS != 0) && We && (Wa == w_ra) && (w_ra <= c_pc_idx);

    always_comb begin
      w_stored = '0;
      for (int i = 0; i < c_ngen; i++) begin
        if (w_ra == AW'(i)) begin
          w_stored = regs_q[i];
        end
      end
      if (w_ra == c_pc_idx) begin
        w_stored = pc_q + c_rd_ofs;
      end
    end

    // A bypassed PC write shows the written value, not a same-cycle branch.
    always_comb begin
      w_rd = w_stored;
      if (w_hit) begin
        w_rd = (w_ra == c_pc_idx) ? (Wd + c_rd_ofs) : Wd;
      end
    end

    assign Rd[k*WIDTH +: WIDTH] = w_rd;
  end

endmodule
`default_nettype wire
